// File: rtl/ram_arbiter.sv
// Two-port arbiter and sequencer for the single-port synchronous RAM.
// Port A is read-only fetch, port B is load/store; whole-memory clears take priority.
module ram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr_req,
   output logic                  clr_done,
   input  logic                  a_req,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   output logic                  a_ack,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_wr,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_ack,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  ram_en,
   output logic                  ram_wr,
   output logic                  ram_reset,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);

   typedef enum logic [2:0] {StIdle, StAccess, StCapture, StAck, StClear} state_e;

   state_e                state_q, state_d;
   logic                  owner_q;     // 0 = A, 1 = B
   logic                  rr_q;        // port that wins the next tie
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  wr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  clr_pend_q, clr_pend_d;
   logic                  clr_done_q;
   logic [DATA_WIDTH-1:0] a_rdata_q;
   logic [DATA_WIDTH-1:0] b_rdata_q;
   logic                  grant;
   logic                  grant_b;
   logic                  bus_drive;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      grant_b = b_req;
      if (a_req && b_req) begin
         grant_b = rr_q;
      end
      grant = (state_q == StIdle) && !clr_pend_q && (a_req || b_req);

      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (clr_pend_q) begin
               state_d = StClear;
            end else if (a_req || b_req) begin
               state_d = StAccess;
            end
         end
         StAccess:  state_d = wr_q ? StAck : StCapture;
         StCapture: state_d = StAck;
         StAck:     state_d = StIdle;
         StClear:   state_d = StIdle;
         default:   state_d = StIdle;
      endcase

      // A request arriving in the clearing cycle re-arms the flag for a second clear.
      clr_pend_d = clr_req || (clr_pend_q && (state_q != StClear));
   end

   // Latched transaction fields, read data and clear bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q    <= 1'b0;
         rr_q       <= 1'b0;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         clr_pend_q <= 1'b0;
         clr_done_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         clr_pend_q <= clr_pend_d;
         clr_done_q <= (state_q == StClear);
         if (grant) begin
            owner_q <= grant_b;
            rr_q    <= !grant_b;
            addr_q  <= grant_b ? b_addr : a_addr;
            wr_q    <= grant_b && b_wr;
            wdata_q <= b_wdata;
         end
         if (state_q == StCapture) begin
            if (owner_q) begin
               b_rdata_q <= ram_data;
            end else begin
               a_rdata_q <= ram_data;
            end
         end
      end
   end

   // Outputs: decodes of state and latched fields only
   always_comb begin
      ram_en    = (state_q == StAccess) || (state_q == StClear);
      ram_wr    = (state_q == StAccess) && wr_q;
      ram_reset = (state_q == StClear);
      ram_addr  = (state_q == StAccess) ? addr_q : '0;
      a_ack     = (state_q == StAck) && !owner_q;
      b_ack     = (state_q == StAck) && owner_q;
      bus_drive = (state_q == StAccess) && wr_q;
      clr_done  = clr_done_q;
      a_rdata   = a_rdata_q;
      b_rdata   = b_rdata_q;
   end

   assign ram_data = bus_drive ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM on the shared bus.
// The RAM model holds the bus at a sentinel whenever the arbiter must not drive it.
module tb_ram_arbiter;

   localparam logic [15:0] SENTINEL = 16'hD00D;

   logic        clk;
   logic        reset;
   logic        clr_req;
   logic        clr_done;
   logic        a_req;
   logic [15:0] a_addr;
   logic        a_ack;
   logic [15:0] a_rdata;
   logic        b_req;
   logic        b_wr;
   logic [15:0] b_addr;
   logic [15:0] b_wdata;
   logic        b_ack;
   logic [15:0] b_rdata;
   logic        ram_en;
   logic        ram_wr;
   logic        ram_reset;
   logic [15:0] ram_addr;
   wire  [15:0] ram_data;

   int n_checks = 0;
   int n_errors = 0;

   ram_arbiter #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .clr_req  (clr_req),
      .clr_done (clr_done),
      .a_req    (a_req),
      .a_addr   (a_addr),
      .a_ack    (a_ack),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_wr     (b_wr),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_ack    (b_ack),
      .b_rdata  (b_rdata),
      .ram_en   (ram_en),
      .ram_wr   (ram_wr),
      .ram_reset(ram_reset),
      .ram_addr (ram_addr),
      .ram_data (ram_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: read data appears on the bus the cycle after a read access
   logic [15:0] mem [0:255];
   logic [15:0] rd_q;
   logic        rd_valid_q = 1'b0;
   logic        tb_drive;

   assign tb_drive = !(ram_en && ram_wr);
   assign ram_data = tb_drive ? (rd_valid_q ? rd_q : SENTINEL) : 16'hzzzz;

   always @(posedge clk) begin
      rd_valid_q <= 1'b0;
      if (ram_en) begin
         if (ram_reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         end else if (ram_wr) begin
            mem[ram_addr[7:0]] <= ram_data;
         end else begin
            rd_q       <= mem[ram_addr[7:0]];
            rd_valid_q <= 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Any extra driver on the bus corrupts the sentinel or the returned read data
   always @(negedge clk) begin
      if (tb_drive) check("bus_owner", {16'h0, ram_data}, {16'h0, rd_valid_q ? rd_q : SENTINEL});
   end

   // One transaction on a port; lat = cycles from request (IDLE) to ack, -1 on timeout
   task automatic txn(input bit use_b, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wdata, output int lat);
      lat = -1;
      if (use_b) begin
         b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wdata;
      end else begin
         a_req = 1'b1; a_addr = addr;
      end
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if ((use_b ? b_ack : a_ack) === 1'b1) begin
            lat = n;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int ack_port [4];
      int ack_cyc  [4];
      int n_ack;
      int first_b, first_a, first_rst, first_done, cnt_rst, cnt_done, wr_in_clr;

      reset = 1'b1; clr_req = 1'b0; a_req = 1'b0; a_addr = '0;
      b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = 16'h0F0F;

      repeat (2) @(negedge clk);
      check("rst_outputs", {26'h0, a_ack, b_ack, clr_done, ram_en, ram_wr, ram_reset}, 32'h0);
      check("rst_ram_addr", {16'h0, ram_addr}, 32'h0);
      check("rst_rdata", {a_rdata, b_rdata}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Write then read on B
      txn(1'b1, 1'b1, 16'h0001, 16'h5A5A, lat);
      txn(1'b1, 1'b1, 16'h0010, 16'hBEEF, lat);
      check("wr_latency", lat, 3);
      check("wr_mem", {16'h0, mem[8'h10]}, 32'h0000BEEF);
      txn(1'b1, 1'b0, 16'h0010, 16'h0F0F, lat);
      check("rd_latency", lat, 4);
      check("rd_b_rdata", {16'h0, b_rdata}, 32'h0000BEEF);
      check("rd_a_rdata_untouched", {16'h0, a_rdata}, 32'h0);

      // Contention straight out of reset: A first, then strict alternation
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      a_req = 1'b1; a_addr = 16'h0001;
      b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h0002; b_wdata = 16'h1234;
      n_ack = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            if (n_ack < 4) begin
               ack_port[n_ack] = b_ack ? 1 : 0;
               ack_cyc[n_ack]  = cyc;
            end
            n_ack++;
         end
         @(posedge clk); #1;
         if (cyc == 14) begin
            a_req = 1'b0; b_req = 1'b0;
         end
      end
      check("cont_ack_count", n_ack, 4);
      check("cont_order", {ack_port[0][7:0], ack_port[1][7:0], ack_port[2][7:0],
            ack_port[3][7:0]}, 32'h00010001);
      check("cont_ack_cycles", {ack_cyc[0][7:0], ack_cyc[1][7:0], ack_cyc[2][7:0],
            ack_cyc[3][7:0]}, {8'd4, 8'd7, 8'd11, 8'd14});
      check("cont_a_rdata", {16'h0, a_rdata}, 32'h00005A5A);
      check("cont_b_mem", {16'h0, mem[8'h02]}, 32'h00001234);

      // Clear requested during B ACCESS beats a pending A request
      first_b = 0; first_a = 0; first_rst = 0; first_done = 0;
      cnt_rst = 0; cnt_done = 0; wr_in_clr = 0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         if (cyc == 1) begin
            b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h0030; b_wdata = 16'h7777;
         end
         if (cyc == 2) begin
            clr_req = 1'b1; a_req = 1'b1; a_addr = 16'h0010;
         end
         if (cyc == 3) clr_req = 1'b0;
         if (cyc == 4) b_req = 1'b0;
         if (cyc == 10) a_req = 1'b0;
         @(negedge clk);
         if (b_ack && first_b == 0) first_b = cyc;
         if (a_ack && first_a == 0) first_a = cyc;
         if (ram_reset) begin
            cnt_rst++;
            if (first_rst == 0) first_rst = cyc;
            if (ram_wr || !ram_en) wr_in_clr++;
         end
         if (clr_done) begin
            cnt_done++;
            if (first_done == 0) first_done = cyc;
         end
         @(posedge clk); #1;
      end
      check("clr_b_ack_cycle", first_b, 3);
      check("clr_cycle", first_rst, 5);
      check("clr_count", cnt_rst, 1);
      check("clr_pins", wr_in_clr, 0);
      check("clr_done_cycle", first_done, 6);
      check("clr_done_count", cnt_done, 1);
      check("clr_a_ack_cycle", first_a, 9);
      check("clr_read_zero", {16'h0, a_rdata}, 32'h0);

      // Several clr_req cycles during one B read merge into a single clear
      txn(1'b1, 1'b1, 16'h0044, 16'hA5A5, lat);
      first_b = 0; first_rst = 0; first_done = 0; cnt_rst = 0; cnt_done = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if (cyc == 1) begin
            b_req = 1'b1; b_wr = 1'b0; b_addr = 16'h0044; b_wdata = 16'h0F0F;
         end
         clr_req = (cyc >= 2 && cyc <= 4);
         if (cyc == 5) b_req = 1'b0;
         @(negedge clk);
         if (b_ack && first_b == 0) first_b = cyc;
         if (ram_reset) begin
            cnt_rst++;
            if (first_rst == 0) first_rst = cyc;
         end
         if (clr_done) begin
            cnt_done++;
            if (first_done == 0) first_done = cyc;
         end
         @(posedge clk); #1;
      end
      check("dbl_b_ack_cycle", first_b, 4);
      check("dbl_b_rdata", {16'h0, b_rdata}, 32'h0000A5A5);
      check("dbl_clr_count", cnt_rst, 1);
      check("dbl_clr_cycle", first_rst, 6);
      check("dbl_done_count", cnt_done, 1);
      check("dbl_done_cycle", first_done, 7);

      // Asynchronous reset in the middle of an A read (CAPTURE)
      txn(1'b1, 1'b1, 16'h0050, 16'h3C3C, lat);
      a_req = 1'b1; a_addr = 16'h0050;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 reset = 1'b1;
      #1;
      check("arst_b_rdata", {16'h0, b_rdata}, 32'h0);
      check("arst_outputs", {26'h0, a_ack, b_ack, clr_done, ram_en, ram_wr, ram_reset}, 32'h0);
      a_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      n_ack = 0;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         @(negedge clk);
         if (a_ack || b_ack) n_ack++;
         @(posedge clk); #1;
      end
      check("arst_no_ack", n_ack, 0);
      txn(1'b0, 1'b0, 16'h0050, 16'h0F0F, lat);
      check("arst_fresh_latency", lat, 4);
      check("arst_fresh_rdata", {16'h0, a_rdata}, 32'h00003C3C);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
